psg_bus_scheduler: RTL

PSG_BUS_SCHEDULER -- requirements
Module: psg_bus_scheduler

---
 rtl/psg_bus_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/psg_bus_scheduler.sv
// Purpose : two-port round-robin scheduler that serialises register accesses onto a PSG bus.
// Latency : address phase (PULSE_LEN + GAP_LEN) is skipped on an address-cache hit; data phase is PULSE_LEN + GAP_LEN;
//           read data appears on the first cycle after the read pulse.
// Backpr. : READY is offered only in IDLE; a requester holds VALID until it sees READY on a rising edge.
//
// Ports
//   CLK, RESET              rising-edge clock, synchronous active-high reset
//   REQn_VALID/READY        request handshake (port 0 = CPU, port 1 = player)
//   REQn_WE/ADDR/WDATA      access type, PSG register number, write data
//   RSPn_VALID, RSP_DATA    one-cycle read-data strobe to the owning port, shared data bus
//   PSG_BDIR/BC/DI, PSG_DO  PSG bus control, data to PSG, data from PSG
//   BUSY                    high whenever an access is in progress
module psg_bus_scheduler #(
   parameter int unsigned PULSE_LEN = 2,
   parameter int unsigned GAP_LEN   = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0_VALID,
   output logic       REQ0_READY,
   input  logic       REQ0_WE,
   input  logic [3:0] REQ0_ADDR,
   input  logic [7:0] REQ0_WDATA,
   input  logic       REQ1_VALID,
   output logic       REQ1_READY,
   input  logic       REQ1_WE,
   input  logic [3:0] REQ1_ADDR,
   input  logic [7:0] REQ1_WDATA,
   output logic       RSP0_VALID,
   output logic       RSP1_VALID,
   output logic [7:0] RSP_DATA,
   output logic       PSG_BDIR,
   output logic       PSG_BC,
   output logic [7:0] PSG_DI,
   input  logic [7:0] PSG_DO,
   output logic       BUSY
);

   localparam logic [3:0] PULSE_LD = 4'(PULSE_LEN - 1);
   localparam logic [3:0] GAP_LD   = 4'(GAP_LEN - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR_HI  = 3'd1,
      ADDR_GAP = 3'd2,
      DATA_HI  = 3'd3,
      RD_HI    = 3'd4,
      DATA_GAP = 3'd5
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   // latched transaction
   logic       cur_port;
   logic       cur_we;
   logic [3:0] cur_addr;
   logic [7:0] cur_wdata;

   // PSG keeps its latched register address, so a repeat access to the
   // same register can skip the address phase
   logic       cache_vld;
   logic [3:0] cache_addr;

   logic       last_grant;
   logic [7:0] di_q;
   logic [7:0] rsp_data_q;
   logic       rsp0_q;
   logic       rsp1_q;

   logic       grant0;
   logic       grant1;
   logic       accept;
   logic       sel_we;
   logic [3:0] sel_addr;
   logic [7:0] sel_wdata;
   logic       addr_hit;
   logic       phase_done;
   logic       bdir_st;
   logic       bc_st;

   // ---------------------------------------------------------------
   // Arbitration and request select
   // ---------------------------------------------------------------
   always_comb begin
      // last_grant = 1 means port 1 was served last, so port 0 wins a tie
      grant0     = REQ0_VALID & (~REQ1_VALID | last_grant);
      grant1     = REQ1_VALID & (~REQ0_VALID | ~last_grant);
      sel_we     = grant0 ? REQ0_WE    : REQ1_WE;
      sel_addr   = grant0 ? REQ0_ADDR  : REQ1_ADDR;
      sel_wdata  = grant0 ? REQ0_WDATA : REQ1_WDATA;
      accept     = (state == IDLE) & (grant0 | grant1) & ~RESET;
      addr_hit   = cache_vld & (cache_addr == sel_addr);
      phase_done = (cnt == 4'd0);
   end

   // ---------------------------------------------------------------
   // Next-state and bus-control decode
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = phase_done ? cnt : cnt - 4'd1;
      bdir_st   = 1'b0;
      bc_st     = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nxt = PULSE_LD;
               if (!addr_hit)
                  state_nxt = ADDR_HI;
               else if (sel_we)
                  state_nxt = DATA_HI;
               else
                  state_nxt = RD_HI;
            end
         end
         ADDR_HI: begin
            bdir_st = 1'b1;
            bc_st   = 1'b1;
            if (phase_done) begin
               state_nxt = ADDR_GAP;
               cnt_nxt   = GAP_LD;
            end
         end
         ADDR_GAP: begin
            if (phase_done) begin
               state_nxt = cur_we ? DATA_HI : RD_HI;
               cnt_nxt   = PULSE_LD;
            end
         end
         DATA_HI: begin
            bdir_st = 1'b1;
            if (phase_done) begin
               state_nxt = DATA_GAP;
               cnt_nxt   = GAP_LD;
            end
         end
         RD_HI: begin
            bc_st = 1'b1;
            if (phase_done) begin
               state_nxt = DATA_GAP;
               cnt_nxt   = GAP_LD;
            end
         end
         DATA_GAP: begin
            if (phase_done)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // State, transaction latch, cache, data registers
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         cur_port   <= 1'b0;
         cur_we     <= 1'b0;
         cur_addr   <= 4'd0;
         cur_wdata  <= 8'd0;
         cache_vld  <= 1'b0;
         cache_addr <= 4'd0;
         last_grant <= 1'b1;
         di_q       <= 8'd0;
         rsp_data_q <= 8'd0;
         rsp0_q     <= 1'b0;
         rsp1_q     <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rsp0_q <= (state == RD_HI) & phase_done & ~cur_port;
         rsp1_q <= (state == RD_HI) & phase_done &  cur_port;

         if (accept) begin
            cur_port   <= grant1;
            last_grant <= grant1;
            cur_we     <= sel_we;
            cur_addr   <= sel_addr;
            cur_wdata  <= sel_wdata;
            // DI is loaded one edge ahead so it is stable for the whole pulse
            if (!addr_hit)
               di_q <= {4'b0000, sel_addr};
            else if (sel_we)
               di_q <= sel_wdata;
         end

         if ((state == ADDR_HI) && phase_done) begin
            cache_vld  <= 1'b1;
            cache_addr <= cur_addr;
         end

         if ((state == ADDR_GAP) && phase_done && cur_we)
            di_q <= cur_wdata;

         if ((state == RD_HI) && phase_done)
            rsp_data_q <= PSG_DO;
      end
   end

   // Combinational outputs are masked during RESET so nothing drives the
   // bus or handshakes while the block is being reset.
   assign REQ0_READY = accept & grant0;
   assign REQ1_READY = accept & grant1;
   assign PSG_BDIR   = bdir_st & ~RESET;
   assign PSG_BC     = bc_st & ~RESET;
   assign BUSY       = (state != IDLE) & ~RESET;
   assign PSG_DI     = di_q;
   assign RSP0_VALID = rsp0_q;
   assign RSP1_VALID = rsp1_q;
   assign RSP_DATA   = rsp_data_q;

endmodule
